// File: rtl/intel_hex_dump.sv
// intel_hex_dump: reads a memory range over a 1-cycle-latency read port and streams it
// as Intel HEX text (type-00 data records, then a type-01 EOF record), one char per transfer.
module intel_hex_dump #(
   parameter int BYTES_PER_RECORD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_start_addr,
   input  logic [15:0] i_length,
   output logic        o_read_en,
   output logic [15:0] o_read_addr,
   input  logic [7:0]  i_read_data,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   input  logic        i_data_ready,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_REC_HDR, S_FETCH, S_WAIT_RD, S_DATA_HI, S_DATA_LO,
      S_CHK_HI, S_CHK_LO, S_CR, S_LF, S_EOF, S_DONE
   } state_t;

   state_t      state, state_nx;
   logic [15:0] addr;
   logic [15:0] remaining;
   logic [7:0]  bytes_left;
   logic [7:0]  data_byte;
   logic [7:0]  chk;
   logic [3:0]  char_idx;
   logic [7:0]  rec_len;
   logic [7:0]  chk_out;
   logic [16:0] lim;
   logic [16:0] to_wrap;
   logic        xfer;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] eof_char(input logic [3:0] idx);
      case (idx)
         4'd0:          return 8'h3A;
         4'd8:          return 8'h31;
         4'd9, 4'd10:   return 8'h46;
         4'd11:         return 8'h0D;
         4'd12:         return 8'h0A;
         default:       return 8'h30;
      endcase
   endfunction

   // Record length is the smallest of bytes left, record capacity and distance to the 64K wrap;
   // addr and remaining stay constant for the whole header, so this is stable while it is emitted.
   always_comb begin
      to_wrap = 17'h10000 - {1'b0, addr};
      lim     = {1'b0, remaining};
      if (to_wrap < lim) lim = to_wrap;
      if (17'(BYTES_PER_RECORD) < lim) lim = 17'(BYTES_PER_RECORD);
      rec_len = lim[7:0];
   end

   assign chk_out      = 8'h00 - chk;
   assign o_data_valid = state inside {S_REC_HDR, S_DATA_HI, S_DATA_LO, S_CHK_HI,
                                       S_CHK_LO, S_CR, S_LF, S_EOF};
   assign xfer         = o_data_valid & i_data_ready;
   assign o_busy       = (state != S_IDLE) && (state != S_DONE);
   assign o_done       = (state == S_DONE);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nx    = state;
      o_data      = 8'h00;
      o_read_en   = 1'b0;
      o_read_addr = 16'h0000;
      case (state)
         S_IDLE: if (i_start) state_nx = (i_length == 16'd0) ? S_EOF : S_REC_HDR;
         S_REC_HDR: begin
            case (char_idx)
               4'd0:    o_data = 8'h3A;
               4'd1:    o_data = hex_char(rec_len[7:4]);
               4'd2:    o_data = hex_char(rec_len[3:0]);
               4'd3:    o_data = hex_char(addr[15:12]);
               4'd4:    o_data = hex_char(addr[11:8]);
               4'd5:    o_data = hex_char(addr[7:4]);
               4'd6:    o_data = hex_char(addr[3:0]);
               default: o_data = 8'h30;
            endcase
            if (xfer && char_idx == 4'd8) state_nx = S_FETCH;
         end
         S_FETCH: begin
            o_read_en   = 1'b1;
            o_read_addr = addr;
            state_nx    = S_WAIT_RD;
         end
         S_WAIT_RD: state_nx = S_DATA_HI;
         S_DATA_HI: begin
            o_data = hex_char(data_byte[7:4]);
            if (xfer) state_nx = S_DATA_LO;
         end
         S_DATA_LO: begin
            o_data = hex_char(data_byte[3:0]);
            if (xfer) state_nx = (bytes_left == 8'd1) ? S_CHK_HI : S_FETCH;
         end
         S_CHK_HI: begin
            o_data = hex_char(chk_out[7:4]);
            if (xfer) state_nx = S_CHK_LO;
         end
         S_CHK_LO: begin
            o_data = hex_char(chk_out[3:0]);
            if (xfer) state_nx = S_CR;
         end
         S_CR: begin
            o_data = 8'h0D;
            if (xfer) state_nx = S_LF;
         end
         S_LF: begin
            o_data = 8'h0A;
            if (xfer) state_nx = (remaining != 16'd0) ? S_REC_HDR : S_EOF;
         end
         S_EOF: begin
            o_data = eof_char(char_idx);
            if (xfer && char_idx == 4'd12) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= 16'h0000;
         remaining  <= 16'h0000;
         bytes_left <= 8'h00;
         data_byte  <= 8'h00;
         chk        <= 8'h00;
         char_idx   <= 4'h0;
      end else begin
         // NOTE: non-blocking so every register sees pre-edge values of the others.
         state <= state_nx;
         case (state)
            S_IDLE: if (i_start) begin
               addr      <= i_start_addr;
               remaining <= i_length;
               char_idx  <= 4'h0;
            end
            S_REC_HDR: if (xfer) begin
               if (char_idx == 4'd8) begin
                  char_idx   <= 4'h0;
                  bytes_left <= rec_len;
                  chk        <= rec_len + addr[15:8] + addr[7:0];
               end else begin
                  char_idx <= char_idx + 4'd1;
               end
            end
            S_WAIT_RD: begin
               data_byte <= i_read_data;
               chk       <= chk + i_read_data;
            end
            S_DATA_LO: if (xfer) begin
               addr       <= addr + 16'd1;
               remaining  <= remaining - 16'd1;
               bytes_left <= bytes_left - 8'd1;
            end
            S_EOF: if (xfer) char_idx <= (char_idx == 4'd12) ? 4'h0 : char_idx + 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_intel_hex_dump.sv
// tb_intel_hex_dump: drives dumps from a random memory image and compares the character
// stream, read addresses and handshake behaviour against a string-level reference model.
module tb_intel_hex_dump;
   localparam int BPR = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [15:0] i_start_addr;
   logic [15:0] i_length;
   logic        o_read_en;
   logic [15:0] o_read_addr;
   logic [7:0]  i_read_data = 8'h00;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        i_data_ready;
   logic        o_busy;
   logic        o_done;

   intel_hex_dump #(.BYTES_PER_RECORD(BPR)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_start_addr (i_start_addr),
      .i_length     (i_length),
      .o_read_en    (o_read_en),
      .o_read_addr  (o_read_addr),
      .i_read_data  (i_read_data),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (i_data_ready),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic [7:0]   mem [65536];
   byte unsigned got[$];
   byte unsigned exp[$];
   logic [15:0]  reads[$];
   int           done_cnt;
   int           stall_err;
   int           bubbles;
   bit           stall_mode;
   logic         prev_stall = 1'b0;
   logic [7:0]   prev_data  = 8'h00;

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk) if (o_read_en) i_read_data <= mem[o_read_addr];

   initial begin
      i_data_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 i_data_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor sampled mid-cycle: a transfer is valid&&ready seen before the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!o_data_valid || o_data !== prev_data)) stall_err++;
         if (o_data_valid && i_data_ready) got.push_back(o_data);
         if (o_read_en) reads.push_back(o_read_addr);
         if (o_done) done_cnt++;
         if (o_busy && !o_data_valid) bubbles++;
         prev_stall = o_data_valid && !i_data_ready;
         prev_data  = o_data;
      end
   end

   function automatic byte unsigned hexc(input int n);
      return (n < 10) ? byte'(48 + n) : byte'(55 + n);
   endfunction

   function automatic void push_hex(input int v);
      exp.push_back(hexc((v >> 4) & 15));
      exp.push_back(hexc(v & 15));
   endfunction

   function automatic void build_expected(input int start_a, input int len);
      int a   = start_a;
      int rem = len;
      int ll, sum, d;
      exp.delete();
      while (rem > 0) begin
         ll = rem;
         if (BPR < ll) ll = BPR;
         if (65536 - a < ll) ll = 65536 - a;
         sum = ll + (a >> 8) + (a & 255);
         exp.push_back(8'h3A);
         push_hex(ll); push_hex(a >> 8); push_hex(a & 255); push_hex(0);
         for (int i = 0; i < ll; i++) begin
            d = int'(mem[(a + i) & 65535]);
            push_hex(d);
            sum += d;
         end
         push_hex((256 - (sum & 255)) & 255);
         exp.push_back(8'h0D);
         exp.push_back(8'h0A);
         a   = (a + ll) & 65535;
         rem -= ll;
      end
      exp.push_back(8'h3A);
      push_hex(0); push_hex(0); push_hex(0); push_hex(1); push_hex(255);
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
   endfunction

   function automatic string got_str();
      string s = "";
      foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
      return s;
   endfunction

   task automatic start_pulse(input logic [15:0] a, input logic [15:0] len);
      @(posedge clk);
      #2;
      i_start_addr = a;
      i_length     = len;
      i_start      = 1'b1;
      @(posedge clk);
      #2 i_start = 1'b0;
   endtask

   // Runs one dump and checks stream, reads, stall stability and the done pulse.
   task automatic run_dump(input string name, input int a, input int len, input bit stall,
                           input bit poke);
      int n = 0;
      int bad;
      build_expected(a, len);
      got.delete();
      reads.delete();
      done_cnt   = 0;
      stall_err  = 0;
      bubbles    = 0;
      stall_mode = stall;
      start_pulse(16'(a), 16'(len));
      while (done_cnt == 0 && n < 20000) begin
         @(posedge clk);
         #2;
         n++;
         if (poke && n == 20) begin
            i_start_addr = 16'(a) ^ 16'h1234;
            i_length     = 16'd5;
            i_start      = 1'b1;
         end else begin
            i_start = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt != 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
      else passed++;
      checks++;
      if (o_busy !== 1'b0) $display("FAIL %s busy_after_done: got %b expected 0", name, o_busy);
      else passed++;
      bad = -1;
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         if (bad < 0 && got[i] !== exp[i]) bad = i;
      if (bad < 0 && got.size() != exp.size()) bad = (got.size() < exp.size()) ? got.size() : exp.size();
      checks++;
      if (bad >= 0)
         $display("FAIL %s stream: first diff at char %0d (got %0d chars, expected %0d chars)",
                  name, bad, got.size(), exp.size());
      else passed++;
      bad = (reads.size() != len) ? 0 : -1;
      foreach (reads[i]) if (bad < 0 && reads[i] !== 16'((a + i) & 65535)) bad = i + 1;
      checks++;
      if (bad >= 0) $display("FAIL %s reads: got %0d reads, mismatch code %0d, expected %0d ascending",
                             name, reads.size(), bad, len);
      else passed++;
      checks++;
      if (stall_err != 0) $display("FAIL %s stall_stability: got %0d violations expected 0",
                                   name, stall_err);
      else passed++;
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({o_data_valid, o_busy, o_done, o_read_en} !== 4'b0000 || o_data !== 8'h00
          || o_read_addr !== 16'h0000)
         $display("FAIL %s: got valid=%b busy=%b done=%b rd=%b data=%h raddr=%h expected all 0",
                  name, o_data_valid, o_busy, o_done, o_read_en, o_data, o_read_addr);
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_start_addr = 16'h0; i_length = 16'h0; stall_mode = 1'b0;
      #1 check_idle_outputs("reset_outputs");
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_len0();
      string s;
      run_dump("len0", 16'h1234, 0, 1'b0, 1'b0);
      s = $sformatf(":00000001FF%c%c", 8'd13, 8'd10);
      checks++;
      if (got_str() != s) $display("FAIL len0_literal: got \"%s\" expected \"%s\"", got_str(), s);
      else passed++;
      checks++;
      if (bubbles != 0) $display("FAIL len0_bubbles: got %0d expected 0", bubbles);
      else passed++;
   endtask

   task automatic test_small(input bit stall);
      string s;
      mem[16'h0F00] = 8'h01; mem[16'h0F01] = 8'h02; mem[16'h0F02] = 8'h03;
      run_dump(stall ? "small_stall" : "small", 16'h0F00, 3, stall, 1'b0);
      s = $sformatf(":030F0000010203E8%c%c:00000001FF%c%c", 8'd13, 8'd10, 8'd13, 8'd10);
      checks++;
      if (got_str() != s) $display("FAIL small_literal: got \"%s\" expected \"%s\"", got_str(), s);
      else passed++;
   endtask

   task automatic test_wrap();
      mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
      run_dump("wrap", 16'hFFFE, 4, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      stall_mode = 1'b0;
      got.delete();
      start_pulse(16'h0000, 16'd17);
      while (!(got.size() >= 12 && o_data_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 1000) $display("FAIL reset_mid_reach: got %0d chars expected >=12", got.size());
      else passed++;
      #2 rst = 1'b1;
      #1 check_idle_outputs("reset_mid_outputs");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      run_dump("after_reset", 16'h0000, 17, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int a, len;
      for (int k = 0; k < 6; k++) begin
         a   = (k % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(65500, 65535));
         len = int'($urandom_range(0, 120));
         run_dump($sformatf("random%0d", k), a, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      test_reset();
      test_len0();
      test_small(1'b0);
      run_dump("len17", 16'h0000, 17, 1'b0, 1'b0);
      test_wrap();
      test_small(1'b1);
      run_dump("start_ignored", 16'h0100, 40, 1'b0, 1'b1);
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
